iccm_stream_loader: RTL and testbench

// - Parametrised boot-image loader for the ICCM: accepts byte streams from NUM_SRC serial front-ends (UART rx, SPI slave, ...).
// - Assembles little-endian words and validates a length-prefixed frame.
// - Drives the ICCM write port and holds the core in reset until a complete image is loaded.
// - Generalises the fixed two-source, fixed-width ICCM controller: any width/depth/source count, explicit length, error reporting, restart.

---
 rtl/iccm_stream_loader.sv | 181 ++++++++++++++++++
 tb/tb_iccm_stream_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iccm_stream_loader.sv
// Boot-image loader: picks one of NUM_SRC byte streams, parses a length-prefixed frame and writes the words to the ICCM.
// Latency: last byte of a data word at cycle t -> we_o at t+1. No backpressure: bytes arrive as 1-cycle strobes and must be taken.
// Optional trailer checksum word when ICCM_LOADER_CHECKSUM_EN is defined.
module iccm_stream_loader #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    localparam int SELW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [SELW-1:0]         src_sel_i,
    input  logic [NUM_SRC-1:0]      src_valid_i,
    input  logic [NUM_SRC*8-1:0]    src_byte_i,
    input  logic                    restart_i,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [ADDR_WIDTH:0]     word_cnt_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    core_rst_req_o
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BCW = $clog2(BPW);
    localparam logic [BCW-1:0]      LAST_B = BCW'(BPW - 1);
    localparam logic [DATA_WIDTH:0] CAP    = (DATA_WIDTH + 1)'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef ICCM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state;
    logic [SELW-1:0]        sel_q;
    logic [BCW-1:0]         bcnt;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [ADDR_WIDTH:0]    len_q;
`ifdef ICCM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  sum_q;
`endif

    logic [SELW-1:0]        cur_sel;
    logic                   acc;
    logic [7:0]             b;
    logic                   sel_bad;
    logic                   busy;
    logic                   last;
    logic [DATA_WIDTH-1:0]  word_full;
    logic [ADDR_WIDTH:0]    cnt_nxt;

    // The selected source is live from src_sel_i only until the first byte is taken.
    always_comb begin
        cur_sel = (state == S_IDLE) ? src_sel_i : sel_q;
        acc     = 1'b0;
        b       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cur_sel == SELW'(k)) begin
                acc = src_valid_i[k];
                b   = src_byte_i[8*k +: 8];
            end
        end
        sel_bad   = (state == S_IDLE) && (|src_valid_i) &&
                    ({1'b0, src_sel_i} >= (SELW + 1)'(NUM_SRC));
        busy      = (state != S_DONE) && (state != S_ERR);
        last      = acc && (bcnt == LAST_B);
        word_full = shreg;
        word_full[DATA_WIDTH-8 +: 8] = b;
        cnt_nxt   = word_cnt_o + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            sel_q          <= '0;
            bcnt           <= '0;
            shreg          <= '0;
            len_q          <= '0;
`ifdef ICCM_LOADER_CHECKSUM_EN
            sum_q          <= '0;
`endif
            we_o           <= 1'b0;
            addr_o         <= '0;
            wdata_o        <= '0;
            word_cnt_o     <= '0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
            core_rst_req_o <= 1'b1;
        end else begin
            we_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_bad) begin
                        state <= S_ERR;
                        err_o <= 1'b1;
                    end else if (acc) begin
                        sel_q <= src_sel_i;
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (last) begin
                        if (word_full == '0 || {1'b0, word_full} > CAP) begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end else begin
                            len_q      <= word_full[ADDR_WIDTH:0];
                            word_cnt_o <= '0;
`ifdef ICCM_LOADER_CHECKSUM_EN
                            sum_q      <= '0;
`endif
                            state      <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last) begin
                        we_o       <= 1'b1;
                        addr_o     <= word_cnt_o[ADDR_WIDTH-1:0];
                        wdata_o    <= word_full;
                        word_cnt_o <= cnt_nxt;
`ifdef ICCM_LOADER_CHECKSUM_EN
                        sum_q      <= sum_q + word_full;
                        if (cnt_nxt == len_q) state <= S_CHK;
`else
                        if (cnt_nxt == len_q) state <= S_DONE;
`endif
                    end
                end
`ifdef ICCM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (last) begin
                        if (word_full == sum_q) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    if (restart_i) begin
                        state          <= S_IDLE;
                        done_o         <= 1'b0;
                        err_o          <= 1'b0;
                        word_cnt_o     <= '0;
                        bcnt           <= '0;
                        core_rst_req_o <= 1'b1;
                    end else begin
                        done_o         <= 1'b1;
                        core_rst_req_o <= 1'b0;
                    end
                end
                default: begin
                    if (restart_i) begin
                        state      <= S_IDLE;
                        done_o     <= 1'b0;
                        err_o      <= 1'b0;
                        word_cnt_o <= '0;
                        bcnt       <= '0;
                    end else begin
                        err_o      <= 1'b1;
                    end
                    core_rst_req_o <= 1'b1;
                end
            endcase

            if (acc && busy && !sel_bad) begin
                shreg[{bcnt, 3'b000} +: 8] <= b;
                bcnt <= last ? '0 : bcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_iccm_stream_loader.sv
// Bench for iccm_stream_loader (ADDR_WIDTH=4): random frames against a frame-level reference model.
module tb_iccm_stream_loader;
    localparam int NS = 2, DW = 32, AW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              restart;
    logic [0:0]        src_sel;
    logic [NS-1:0]     src_valid;
    logic [NS*8-1:0]   src_byte;
    logic              we_o;
    logic [AW-1:0]     addr_o;
    logic [DW-1:0]     wdata_o;
    logic [AW:0]       word_cnt_o;
    logic              done_o, err_o, core_rst_req_o;

    iccm_stream_loader #(.NUM_SRC(NS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .src_sel_i(src_sel), .src_valid_i(src_valid),
        .src_byte_i(src_byte), .restart_i(restart), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .word_cnt_o(word_cnt_o), .done_o(done_o), .err_o(err_o),
        .core_rst_req_o(core_rst_req_o));

    always #5 clk = ~clk;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t          exp_q[$];
    byte unsigned fr[$];
    bit           exp_done, exp_err;
    int           exp_cnt;
    int           act_sel;
    int           vecs = 0, errs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(int idx);
        return {fr[idx+3], fr[idx+2], fr[idx+1], fr[idx]};
    endfunction

    // Frame-level reference: what an ideal loader writes for the byte list fr.
    function automatic void model();
        logic [31:0] n, sum;
        exp_done = 0; exp_err = 0; exp_cnt = 0; sum = '0;
        if (fr.size() < 4) return;
        n = word_at(0);
        if (n == 0 || n > (1 << AW)) begin exp_err = 1; return; end
        for (int i = 0; i < int'(n); i++) begin
            if (4 + 4*i + 3 >= fr.size()) return;
            exp_q.push_back('{i, word_at(4 + 4*i)});
            sum += word_at(4 + 4*i);
            exp_cnt++;
        end
`ifdef ICCM_LOADER_CHECKSUM_EN
        if (fr.size() >= 4 + 4*int'(n) + 4) begin
            if (word_at(4 + 4*int'(n)) == sum) exp_done = 1; else exp_err = 1;
        end
`else
        exp_done = 1;
`endif
    endfunction

    function automatic void push_word(logic [31:0] w);
        for (int i = 0; i < 4; i++) fr.push_back(w[8*i +: 8]);
    endfunction

    // Builds header + words + trailer (correct or corrupted) + junk tail.
    function automatic void mk(logic [31:0] hdr, int nw, bit bad_sum, int extra);
        logic [31:0] s, w;
        fr.delete();
        push_word(hdr);
        s = '0;
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            push_word(w);
            s += w;
        end
        push_word(bad_sum ? s + 32'd1 : s);
        for (int i = 0; i < extra; i++) fr.push_back(8'($urandom));
    endfunction

    task automatic cyc(input bit v, input byte unsigned b, input bit junk);
        int other;
        other = 1 - act_sel;
        src_valid = '0;
        if (junk) begin
            src_valid[other] = 1'($urandom_range(0, 1));
            src_byte[8*other +: 8] = 8'($urandom);
        end
        if (v) begin
            src_valid[act_sel] = 1'b1;
            src_byte[8*act_sel +: 8] = b;
        end
        @(posedge clk); #1;
        src_valid = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n && we_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("we_addr", addr_o, e.addr);
                check("we_data", wdata_o, e.data);
            end
        end
    end

    task automatic send(input int sel, input bit junk, input bit toggle, input bit gaps);
        act_sel = sel;
        src_sel = sel[0];
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cyc(0, 0, junk);
            cyc(1, fr[i], junk);
            check("we_latency", we_o, (i >= 7 && i % 4 == 3 && (i/4 - 1) < exp_cnt) ? 1 : 0);
            if (toggle) src_sel = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic finish_frame(input bit junk);
        repeat (3) cyc(0, 0, junk);
        check("writes_outstanding", exp_q.size(), 0);
        check("done", done_o, exp_done);
        check("err", err_o, exp_err);
        check("core_rst_req", core_rst_req_o, !exp_done);
        check("word_cnt", word_cnt_o, exp_cnt);
        if (exp_done || exp_err) begin
            restart = 1'b1;
            cyc(1, 8'($urandom), 0);
            restart = 1'b0;
            check("restart_done", done_o, 0);
            check("restart_err", err_o, 0);
            check("restart_cnt", word_cnt_o, 0);
            check("restart_core_rst", core_rst_req_o, 1);
        end
    endtask

    task automatic run_frame(input int sel, input bit junk, input bit toggle);
        model();
        send(sel, junk, toggle, 1);
        finish_frame(junk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, we_o, 0);
        check({tag, "_addr"}, addr_o, 0);
        check({tag, "_wdata"}, wdata_o, 0);
        check({tag, "_cnt"}, word_cnt_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_core_rst"}, core_rst_req_o, 1);
    endtask

    initial begin
        rst_n = 0; restart = 0; src_sel = '0; src_valid = '0; src_byte = '0; act_sel = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1;

        // Reference frame: 2 words, no gaps, src0; then done timing pinned by hand.
        fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef ICCM_LOADER_CHECKSUM_EN
        push_word(32'hF0E21567);
`endif
        model();
        check("model_w0_addr", exp_q[0].addr, 0);
        check("model_w0_data", exp_q[0].data, 32'h12345678);
        check("model_w1_addr", exp_q[1].addr, 1);
        check("model_w1_data", exp_q[1].data, 32'hDEADBEEF);
        check("model_done", exp_done, 1);
        send(0, 0, 0, 0);
        check("done_not_yet", done_o, 0);
        cyc(0, 0, 0);
        check("done_next_cycle", done_o, 1);
        check("core_released", core_rst_req_o, 0);
        finish_frame(0);

        // Same frame on src1 with junk on src0 and select toggling.
        fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef ICCM_LOADER_CHECKSUM_EN
        push_word(32'hF0E21567);
`endif
        run_frame(1, 1, 1);

        mk(32'd0, 2, 0, 0);   run_frame(0, 1, 0);
        check("model_len0_err", exp_err, 1);
        mk(32'd17, 3, 0, 0);  run_frame(1, 1, 1);
        mk(32'd16, 16, 0, 2); run_frame(0, 1, 1);
        check("model_full_cnt", exp_cnt, 16);

        // Checksum frames: words 1,2 with trailer 3 / 4, then a good frame.
        fr.delete(); push_word(2); push_word(1); push_word(2); push_word(3);
        run_frame(0, 1, 0);
        fr.delete(); push_word(2); push_word(1); push_word(2); push_word(4);
        run_frame(1, 1, 1);
        fr.delete(); push_word(2); push_word(1); push_word(2); push_word(3);
        run_frame(0, 0, 0);

        // Reset after 5 data bytes, then a clean frame.
        mk(32'd3, 3, 0, 0);
        fr = fr[0:8];
        model();
        send(0, 1, 1, 1);
        rst_n = 0;
        @(posedge clk); #1;
        check_reset_vals("midreset");
        rst_n = 1;
        check("midreset_writes", exp_q.size(), 0);
        mk(32'd3, 3, 0, 1);   run_frame(1, 1, 1);

        for (int f = 0; f < 15; f++) begin
            int r, n;
            r = $urandom_range(0, 9);
            n = (r == 0) ? 0 : (r == 1) ? $urandom_range(17, 40) : $urandom_range(1, 16);
            mk(32'(n), (n > 16) ? 2 : n, $urandom_range(0, 3) == 0, $urandom_range(0, 5));
            run_frame($urandom_range(0, 1), 1'($urandom_range(0, 1)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
